bsmem_hs: RTL and testbench

Parametrised, byte-striped, single-port on-chip memory with a valid/ready request/response interface. It supports byte-granular, optionally misaligned accesses that may straddle a word boundary. It succeeds the fixed 4-lane scratch memory used by the core's load/store path. Unlike its predecessor, it supports configurable lane count and depth, backpressure via a 2-entry response buffer, address wrap at the top of memory, and out-of-range error reporting.

---
 rtl/bsmem_hs_pkg.sv | 49 ++++
 rtl/bsmem_hs_if.sv | 30 +++
 rtl/bsmem_lane.sv | 34 +++
 rtl/bsmem_hs.sv | 192 +++++++++++++++++++
 tb/tb_bsmem_hs.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/bsmem_hs_pkg.sv
// Shared types and helpers for the byte-striped memory.
// Provides index-width functions, byte-lane rotation helpers and the response record.
// The rotation helpers work on a maximum-width vector. Callers zero-extend their data into it
// and truncate the result back to their own width.
package bsmem_hs_pkg;

   localparam int unsigned MaxLanes = 64;
   localparam int unsigned MaxDataW = 8 * MaxLanes;

   typedef logic [MaxDataW-1:0] wide_t;

   typedef struct packed {
      logic  err;
      wide_t rdata;
   } rsp_t;

   // Bits needed to select a byte lane (never less than one).
   function automatic int unsigned lane_idx_w(input int unsigned nbytes);
      return (nbytes > 1) ? $clog2(nbytes) : 1;
   endfunction

   // Bits needed to select a word inside one lane (never less than one).
   function automatic int unsigned word_idx_w(input int unsigned depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

   // Byte k of d moves to position (k + sh) mod n.
   function automatic wide_t rotl_bytes(input wide_t d, input int unsigned n,
                                        input int unsigned sh);
      wide_t r;
      r = '0;
      for (int unsigned k = 0; k < MaxLanes; k++) begin
         if (k < n) r[8*((k + sh) & (n - 1)) +: 8] = d[8*k +: 8];
      end
      return r;
   endfunction

   // Byte k of the result is byte (k + sh) mod n of d.
   function automatic wide_t rotr_bytes(input wide_t d, input int unsigned n,
                                        input int unsigned sh);
      wide_t r;
      r = '0;
      for (int unsigned k = 0; k < MaxLanes; k++) begin
         if (k < n) r[8*k +: 8] = d[8*((k + sh) & (n - 1)) +: 8];
      end
      return r;
   endfunction

endpackage

// File: rtl/bsmem_hs_if.sv
// Request/response bundle for bsmem_hs.
// Request channel: req_valid, req_ready, req_addr, req_wstrb (all-zero = read) and req_wdata.
// Response channel: rsp_valid, rsp_ready, rsp_rdata and rsp_err.
// The master modport is the requester. The slave modport is the memory.
interface bsmem_hs_if #(
   parameter int unsigned NBYTES = 4,
   parameter int unsigned ADDR_W = 32
);

   logic                  req_valid;
   logic                  req_ready;
   logic [ADDR_W-1:0]     req_addr;
   logic [NBYTES-1:0]     req_wstrb;
   logic [8*NBYTES-1:0]   req_wdata;
   logic                  rsp_valid;
   logic                  rsp_ready;
   logic [8*NBYTES-1:0]   rsp_rdata;
   logic                  rsp_err;

   modport master (
      output req_valid, req_addr, req_wstrb, req_wdata, rsp_ready,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err
   );

   modport slave (
      input  req_valid, req_addr, req_wstrb, req_wdata, rsp_ready,
      output req_ready, rsp_valid, rsp_rdata, rsp_err
   );

endinterface

// File: rtl/bsmem_lane.sv
// One byte lane: an 8-bit x DEPTH synchronous RAM with a registered read port.
// Ports:
//   clk_i   - clock
//   we_i    - write mem[addr_i] with wdata_i
//   re_i    - load mem[addr_i] into the read register
//   addr_i  - word index
//   wdata_i - write byte
//   rdata_o - registered read byte (held until the next re_i)
// Contents and the read register are intentionally not reset.
module bsmem_lane
   import bsmem_hs_pkg::*;
#(
   parameter int unsigned DEPTH = 2048,
   localparam int unsigned AddrW = word_idx_w(DEPTH)
) (
   input  logic             clk_i,
   input  logic             we_i,
   input  logic             re_i,
   input  logic [AddrW-1:0] addr_i,
   input  logic [7:0]       wdata_i,
   output logic [7:0]       rdata_o
);

   logic [7:0] mem_q [DEPTH];
   logic [7:0] rdata_q;

   always_ff @(posedge clk_i) begin
      if (we_i) mem_q[addr_i] <= wdata_i;
      if (re_i) rdata_q <= mem_q[addr_i];
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/bsmem_hs.sv
// Byte-striped single-port memory with a valid/ready request/response interface.
// Ports:
//   clk_i  - clock
//   rst_ni - asynchronous active-low reset (memory contents survive it)
//   bus    - bsmem_hs_if.slave: request (addr/wstrb/wdata) and response (rdata/err)
// A request may address any byte. Byte k lives in lane (addr + k) mod NBYTES. Lanes below the
// start offset use the next word, which wraps to word 0 at the top of memory.
// Out-of-range addresses return err with no side effect.
// Build option BSMEM_HS_MISALIGN_EN enables misaligned and straddling accesses. Without it, a
// nonzero offset is an error and no lane rotation logic is built.
// Response path: S1 holds the RAM output, followed by a 2-entry FIFO that S1 bypasses when
// empty. req_ready depends only on registers.
module bsmem_hs
   import bsmem_hs_pkg::*;
#(
   parameter int unsigned NBYTES = 4,
   parameter int unsigned DEPTH  = 2048,
   parameter int unsigned ADDR_W = 32
) (
   input logic       clk_i,
   input logic       rst_ni,
   bsmem_hs_if.slave bus
);

   localparam int unsigned OffW  = lane_idx_w(NBYTES);
   localparam int unsigned WordW = word_idx_w(DEPTH);
   localparam int unsigned SpanW = OffW + WordW;
   localparam int unsigned DataW = 8 * NBYTES;

   typedef struct packed {
      logic             err;
      logic [DataW-1:0] rdata;
   } resp_t;

   // Request decode
   logic [OffW-1:0]  off;
   logic [WordW-1:0] word;
   logic             oor, req_err, accept, is_read;

   assign off     = bus.req_addr[OffW-1:0];
   assign word    = bus.req_addr[SpanW-1:OffW];
   assign accept  = bus.req_valid & bus.req_ready;
   assign is_read = (bus.req_wstrb == '0);

   if (ADDR_W > SpanW) begin : g_oor
      assign oor = |bus.req_addr[ADDR_W-1:SpanW];
   end else begin : g_no_oor
      assign oor = 1'b0;
   end

`ifdef BSMEM_HS_MISALIGN_EN
   assign req_err = oor;
`else
   assign req_err = oor | (off != '0);
`endif

   // Lane steering
   logic [NBYTES-1:0]            lane_strb, lane_we;
   logic                         lane_re;
   logic [DataW-1:0]             lane_wdata, lane_rdata;
   logic [NBYTES-1:0][WordW-1:0] lane_addr;

`ifdef BSMEM_HS_MISALIGN_EN
   logic [WordW-1:0] word_inc;
   assign word_inc = word + WordW'(1);

   always_comb begin
      lane_wdata = DataW'(rotl_bytes(MaxDataW'(bus.req_wdata), NBYTES, 32'(off)));
      lane_strb  = '0;
      for (int unsigned k = 0; k < NBYTES; k++) begin
         lane_strb[OffW'(k + 32'(off))] = bus.req_wstrb[k];
      end
      // Lanes before the start offset hold the tail of the access in the next word.
      for (int unsigned i = 0; i < NBYTES; i++) begin
         lane_addr[i] = (OffW'(i) < off) ? word_inc : word;
      end
   end
`else
   always_comb begin
      lane_wdata = bus.req_wdata;
      lane_strb  = bus.req_wstrb;
      for (int unsigned i = 0; i < NBYTES; i++) begin
         lane_addr[i] = word;
      end
   end
`endif

   assign lane_we = {NBYTES{accept & ~req_err}} & lane_strb;
   assign lane_re = accept & ~req_err & is_read;

   for (genvar i = 0; i < NBYTES; i++) begin : g_lane
      bsmem_lane #(
         .DEPTH (DEPTH)
      ) u_lane (
         .clk_i   (clk_i),
         .we_i    (lane_we[i]),
         .re_i    (lane_re),
         .addr_i  (lane_addr[i]),
         .wdata_i (lane_wdata[8*i +: 8]),
         .rdata_o (lane_rdata[8*i +: 8])
      );
   end

   // Stage S1: the lane read registers plus the tags stored here.
   logic s1_valid_q, s1_err_q, s1_zero_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         s1_valid_q <= 1'b0;
         s1_err_q   <= 1'b0;
         s1_zero_q  <= 1'b1;
      end else begin
         s1_valid_q <= accept;
         if (accept) begin
            s1_err_q  <= req_err;
            s1_zero_q <= req_err | ~is_read;
         end
      end
   end

   resp_t s1_rsp;

`ifdef BSMEM_HS_MISALIGN_EN
   logic [OffW-1:0] s1_off_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)     s1_off_q <= '0;
      else if (accept) s1_off_q <= off;
   end

   always_comb begin
      s1_rsp.err   = s1_err_q;
      s1_rsp.rdata = s1_zero_q ? '0 :
                     DataW'(rotr_bytes(MaxDataW'(lane_rdata), NBYTES, 32'(s1_off_q)));
   end
`else
   always_comb begin
      s1_rsp.err   = s1_err_q;
      s1_rsp.rdata = s1_zero_q ? '0 : lane_rdata;
   end
`endif

   // Response FIFO. S1 is always drained in one cycle, either to the consumer or into the
   // FIFO, so S1 can take every accepted request.
   resp_t [1:0] fifo_q;
   logic [1:0]  cnt_q, cnt_d;
   logic        rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   logic        fifo_empty, push, pop;

   assign fifo_empty = (cnt_q == 2'd0);
   assign pop        = ~fifo_empty & bus.rsp_ready;
   assign push       = s1_valid_q & ~(fifo_empty & bus.rsp_ready);

   always_comb begin
      cnt_d    = cnt_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      if (push) wr_ptr_d = ~wr_ptr_q;
      if (pop)  rd_ptr_d = ~rd_ptr_q;
      case ({push, pop})
         2'b10:   cnt_d = cnt_q + 2'd1;
         2'b01:   cnt_d = cnt_q - 2'd1;
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         fifo_q   <= '0;
         cnt_q    <= 2'd0;
         rd_ptr_q <= 1'b0;
         wr_ptr_q <= 1'b0;
      end else begin
         if (push) fifo_q[wr_ptr_q] <= s1_rsp;
         cnt_q    <= cnt_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
      end
   end

   resp_t rsp_out;

   always_comb begin
      rsp_out       = fifo_empty ? s1_rsp : fifo_q[rd_ptr_q];
      bus.rsp_valid = fifo_empty ? s1_valid_q : 1'b1;
      bus.rsp_err   = rsp_out.err;
      bus.rsp_rdata = rsp_out.rdata;
      // Two responses in flight or buffered is the limit.
      bus.req_ready = (2'(s1_valid_q) + cnt_q) < 2'd2;
   end

endmodule

// File: tb/tb_bsmem_hs.sv
// Self-checking bench for bsmem_hs.
// A byte-array model predicts each response when its request is accepted. Responses are
// compared in order as they are consumed.
module tb_bsmem_hs;

   localparam int unsigned NB       = 4;
   localparam int unsigned DP       = 2048;
   localparam int unsigned AW       = 32;
   localparam int unsigned MemBytes = NB * DP;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   bsmem_hs_if #(.NBYTES(NB), .ADDR_W(AW)) bus ();

   bsmem_hs #(
      .NBYTES (NB),
      .DEPTH  (DP),
      .ADDR_W (AW)
   ) dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .bus    (bus)
   );

   typedef struct {
      logic        err;
      logic [31:0] rdata;
   } exp_t;

   exp_t        exp_q[$];
   logic [7:0]  mem_m [MemBytes];
   int unsigned n_cmp = 0, n_err = 0, n_acc = 0, n_rsp = 0;
   logic        last_err;
   logic [31:0] last_rdata;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Byte-addressed view of the memory: byte k of an access is address (addr + k) mod size.
   task automatic model_req(input logic [31:0] addr, input logic [3:0] strb,
                            input logic [31:0] wdata, output exp_t e);
      int unsigned a;
      e.err   = (addr >= MemBytes);
`ifndef BSMEM_HS_MISALIGN_EN
      if ((addr % NB) != 0) e.err = 1'b1;
`endif
      e.rdata = '0;
      if (!e.err) begin
         for (int unsigned k = 0; k < NB; k++) begin
            a = (addr + k) % MemBytes;
            if (strb[k])          mem_m[a] = wdata[8*k +: 8];
            else if (strb == 4'h0) e.rdata[8*k +: 8] = mem_m[a];
         end
      end
   endtask

   exp_t mon_e;

   always @(negedge clk) begin
      if (rst_n) begin
         if (bus.rsp_valid && bus.rsp_ready) begin
            n_rsp++;
            if (exp_q.size() == 0) begin
               check_val("rsp_extra", 64'(exp_q.size()), 64'd1);
            end else begin
               mon_e = exp_q.pop_front();
               check_val("rsp_err", 64'(bus.rsp_err), 64'(mon_e.err));
               check_val("rsp_rdata", 64'(bus.rsp_rdata), 64'(mon_e.rdata));
            end
            last_err   = bus.rsp_err;
            last_rdata = bus.rsp_rdata;
         end
         if (bus.req_valid && bus.req_ready) begin
            model_req(bus.req_addr, bus.req_wstrb, bus.req_wdata, mon_e);
            exp_q.push_back(mon_e);
            n_acc++;
         end
      end
   end

   // Called just after a rising edge; returns just after the edge that accepted the request.
   task automatic do_req(input logic [31:0] addr, input logic [3:0] strb, input logic [31:0] wdata);
      logic acc;
      acc           = 1'b0;
      bus.req_valid = 1'b1;
      bus.req_addr  = addr;
      bus.req_wstrb = strb;
      bus.req_wdata = wdata;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (bus.req_ready) begin
            acc = 1'b1;
            break;
         end
      end
      if (!acc) check_val("req_timeout", 64'(acc), 64'd1);
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 100; i++) begin
         if (exp_q.size() == 0) break;
         @(posedge clk);
         #1;
      end
      if (exp_q.size() != 0) check_val("drain", 64'(exp_q.size()), 64'd0);
   endtask

   initial begin
      logic acc;
      int unsigned r;

      bus.req_valid = 1'b0;
      bus.req_addr  = '0;
      bus.req_wstrb = '0;
      bus.req_wdata = '0;
      bus.rsp_ready = 1'b1;

      #12;
      check_val("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
      check_val("rst_rsp_err", 64'(bus.rsp_err), 64'd0);
      check_val("rst_rsp_rdata", 64'(bus.rsp_rdata), 64'd0);
      check_val("rst_req_ready", 64'(bus.req_ready), 64'd1);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Give every byte a known value.
      for (int unsigned w = 0; w < DP; w++) do_req(w * NB, 4'hF, $urandom);
      drain();

      // Aligned write then read, with one-cycle read latency.
      do_req(32'h10, 4'hF, 32'hDEADBEEF);
      do_req(32'h10, 4'h0, 32'h0);
      @(negedge clk);
      check_val("lat_valid", 64'(bus.rsp_valid), 64'd1);
      check_val("rd_10", 64'(bus.rsp_rdata), 64'hDEADBEEF);
      check_val("rd_10_err", 64'(bus.rsp_err), 64'd0);
      @(negedge clk);
      check_val("lat_once", 64'(bus.rsp_valid), 64'd0);
      @(posedge clk);
      #1;

`ifdef BSMEM_HS_MISALIGN_EN
      do_req(32'h13, 4'hF, 32'h11223344);
      do_req(32'h13, 4'h0, 32'h0);
      drain();
      check_val("mis_13", 64'(last_rdata), 64'h11223344);
      do_req(32'h10, 4'h0, 32'h0);
      drain();
      check_val("mis_10_b3", 64'(last_rdata[31:24]), 64'h44);
      do_req(32'h14, 4'h0, 32'h0);
      drain();
      check_val("mis_14_lo", 64'(last_rdata[23:0]), 64'h112233);
      do_req(32'h1FFE, 4'hF, 32'hAABBCCDD);
      do_req(32'h0, 4'h0, 32'h0);
      drain();
      check_val("wrap_0", 64'(last_rdata[15:0]), 64'hAABB);
      do_req(32'h1FFC, 4'h0, 32'h0);
      drain();
      check_val("wrap_1ffc", 64'(last_rdata[31:16]), 64'hCCDD);
`else
      do_req(32'h13, 4'hF, 32'h11223344);
      drain();
      check_val("mis_err", 64'(last_err), 64'd1);
      do_req(32'h10, 4'h0, 32'h0);
      drain();
      check_val("mis_nowrite", 64'(last_rdata), 64'hDEADBEEF);
      do_req(32'h1FFE, 4'hF, 32'hAABBCCDD);
      drain();
      check_val("wrap_err", 64'(last_err), 64'd1);
`endif

      // Out of range write leaves memory alone.
      do_req(32'h2000, 4'hF, 32'h12345678);
      drain();
      check_val("oor_err", 64'(last_err), 64'd1);
      check_val("oor_rdata", 64'(last_rdata), 64'd0);
      do_req(32'h0, 4'h0, 32'h0);
      drain();

      // Backpressure: two responses buffered, third request waits.
      bus.rsp_ready = 1'b0;
      do_req(32'h100, 4'h0, 32'h0);
      do_req(32'h104, 4'h0, 32'h0);
      bus.req_valid = 1'b1;
      bus.req_addr  = 32'h108;
      bus.req_wstrb = 4'h0;
      @(negedge clk);
      check_val("bp_ready", 64'(bus.req_ready), 64'd0);
      @(negedge clk);
      check_val("bp_hold", 64'(bus.req_ready), 64'd0);
      check_val("bp_valid", 64'(bus.rsp_valid), 64'd1);
      @(posedge clk);
      #1;
      bus.rsp_ready = 1'b1;
      acc = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (bus.req_ready) begin
            acc = 1'b1;
            break;
         end
      end
      if (!acc) check_val("bp_timeout", 64'(acc), 64'd1);
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      drain();

      // Random traffic with random response stalls.
      for (int c = 0; c < 600; c++) begin
         r = $urandom_range(15, 0);
         if (r == 0)      bus.req_addr = $urandom | 32'h0000_2000;
         else if (r == 1) bus.req_addr = 32'h1FF8 + $urandom_range(7, 0);
         else             bus.req_addr = 32'h200 + $urandom_range(31, 0);
         bus.req_wstrb = ($urandom_range(1, 0) == 1) ? 4'h0 : 4'($urandom_range(15, 0));
         bus.req_wdata = $urandom;
         bus.req_valid = ($urandom_range(3, 0) != 0);
         bus.rsp_ready = ($urandom_range(3, 0) != 0);
         @(posedge clk);
         #1;
      end
      bus.req_valid = 1'b0;
      bus.rsp_ready = 1'b1;
      drain();
      check_val("rsp_count", 64'(n_rsp), 64'(n_acc));

      // Reset with two responses buffered.
      do_req(32'h40, 4'hF, 32'hCAFEF00D);
      drain();
      bus.rsp_ready = 1'b0;
      do_req(32'h200, 4'h0, 32'h0);
      do_req(32'h204, 4'h0, 32'h0);
      @(negedge clk);
      check_val("pre_rst_valid", 64'(bus.rsp_valid), 64'd1);
      check_val("pre_rst_ready", 64'(bus.req_ready), 64'd0);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      exp_q.delete();
      #1;
      check_val("rst_async_valid", 64'(bus.rsp_valid), 64'd0);
      check_val("rst_async_ready", 64'(bus.req_ready), 64'd1);
      @(negedge clk);
      #1;
      rst_n = 1'b1;
      bus.rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      do_req(32'h40, 4'h0, 32'h0);
      drain();
      check_val("rst_keep", 64'(last_rdata), 64'hCAFEF00D);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
